// File: rtl/mask_bbox_tracker.sv
// Mask bounding-box tracker.
// Sits after the green-threshold filter. It follows pixel coordinates from the
// sync and blank signals. For every frame it finds the bounding box, the hit
// count and the box centre of the mask pixels, and publishes them once per frame.
// The VGA stream passes through with one cycle of delay. The last published box
// can be drawn over the stream in red.
//
// Handshake: result_valid is a single-cycle strobe with no back-pressure. The
// published fields are valid from that cycle on and hold until the next strobe.
module mask_bbox_tracker #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int MIN_COUNT = 16,
  parameter int COUNT_W   = 19
) (
  input  logic               VGA_CLK,
  input  logic               reset,
  input  logic [7:0]         iVGA_R,
  input  logic [7:0]         iVGA_G,
  input  logic [7:0]         iVGA_B,
  input  logic               iVGA_HS,
  input  logic               iVGA_VS,
  input  logic               iVGA_SYNC_N,
  input  logic               iVGA_BLANK_N,
  input  logic               overlay_en,
  output logic [7:0]         oVGA_R,
  output logic [7:0]         oVGA_G,
  output logic [7:0]         oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_SYNC_N,
  output logic               oVGA_BLANK_N,
  output logic [9:0]         box_xmin,
  output logic [9:0]         box_xmax,
  output logic [9:0]         box_ymin,
  output logic [9:0]         box_ymax,
  output logic [9:0]         center_x,
  output logic [9:0]         center_y,
  output logic [COUNT_W-1:0] pix_count,
  output logic               found,
  output logic               result_valid
);

  localparam logic [9:0]         X_LAST    = 10'(WIDTH - 1);
  localparam logic [9:0]         Y_LAST    = 10'(HEIGHT - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_MIN = COUNT_W'(MIN_COUNT);

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_VSYNC   = 2'd1,
    S_ACTIVE  = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [9:0]         x;
  logic [9:0]         y;
  logic               prev_vs;
  logic               prev_blank;
  logic               hit;
  logic               vs_rise;
  logic               vs_fall;
  logic               blank_fall;

  logic               acc_clear;
  logic               acc_update;
  logic               publish;

  logic [9:0]         acc_xmin;
  logic [9:0]         acc_xmax;
  logic [9:0]         acc_ymin;
  logic [9:0]         acc_ymax;
  logic [COUNT_W-1:0] acc_count;

  logic [10:0]        sum_x;
  logic [10:0]        sum_y;
  logic               on_vert;
  logic               on_horz;
  logic               overlay;

  assign hit        = iVGA_BLANK_N && iVGA_G[7];
  assign vs_rise    = iVGA_VS && !prev_vs;
  assign vs_fall    = !iVGA_VS && prev_vs;
  assign blank_fall = prev_blank && !iVGA_BLANK_N;

  // Remember the previous sync and blank levels so edges can be detected.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      prev_vs    <= 1'b0;
      prev_blank <= 1'b0;
    end else begin
      prev_vs    <= iVGA_VS;
      prev_blank <= iVGA_BLANK_N;
    end
  end

  // Track the coordinate of the pixel on the input in the current cycle.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      if (!iVGA_BLANK_N)   x <= '0;
      else if (x != X_LAST) x <= x + 10'd1;

      if (!iVGA_VS)                      y <= '0;
      else if (blank_fall && y != Y_LAST) y <= y + 10'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge VGA_CLK) begin
    if (reset) state <= S_SYNC;
    else       state <= state_next;
  end

  // FSM next-state logic. The partial frame seen after reset is skipped.
  always_comb begin
    state_next = state;
    case (state)
      S_SYNC:    if (!iVGA_VS) state_next = S_VSYNC;
      S_VSYNC:   if (vs_rise)  state_next = S_ACTIVE;
      S_ACTIVE:  if (vs_fall)  state_next = S_PUBLISH;
      S_PUBLISH: state_next = S_VSYNC;
      default:   state_next = S_SYNC;
    endcase
  end

  // FSM outputs: decode the state into accumulator and publish controls.
  always_comb begin
    acc_clear  = 1'b0;
    acc_update = 1'b0;
    publish    = 1'b0;
    case (state)
      S_VSYNC:   acc_clear  = 1'b1;
      S_ACTIVE:  acc_update = hit;
      S_PUBLISH: publish    = 1'b1;
      default:   ;
    endcase
  end

  // Per-frame accumulators. A hit in the cycle of the VS fall still counts.
  always_ff @(posedge VGA_CLK) begin
    if (reset || acc_clear) begin
      acc_xmin  <= X_LAST;
      acc_xmax  <= '0;
      acc_ymin  <= Y_LAST;
      acc_ymax  <= '0;
      acc_count <= '0;
    end else if (acc_update) begin
      if (x < acc_xmin) acc_xmin <= x;
      if (x > acc_xmax) acc_xmax <= x;
      if (y < acc_ymin) acc_ymin <= y;
      if (y > acc_ymax) acc_ymax <= y;
      if (acc_count != COUNT_MAX) acc_count <= acc_count + 1'b1;
    end
  end

  assign sum_x = {1'b0, acc_xmin} + {1'b0, acc_xmax};
  assign sum_y = {1'b0, acc_ymin} + {1'b0, acc_ymax};

  // Publish the frame results. An empty frame reads back as an all-zero box.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      box_xmin     <= '0;
      box_xmax     <= '0;
      box_ymin     <= '0;
      box_ymax     <= '0;
      center_x     <= '0;
      center_y     <= '0;
      pix_count    <= '0;
      found        <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= publish;
      if (publish) begin
        pix_count <= acc_count;
        found     <= (acc_count != '0) && (acc_count >= COUNT_MIN);
        if (acc_count == '0) begin
          box_xmin <= '0;
          box_xmax <= '0;
          box_ymin <= '0;
          box_ymax <= '0;
          center_x <= '0;
          center_y <= '0;
        end else begin
          box_xmin <= acc_xmin;
          box_xmax <= acc_xmax;
          box_ymin <= acc_ymin;
          box_ymax <= acc_ymax;
          center_x <= sum_x[10:1];
          center_y <= sum_y[10:1];
        end
      end
    end
  end

  assign on_vert = (x == box_xmin || x == box_xmax) && (y >= box_ymin) && (y <= box_ymax);
  assign on_horz = (y == box_ymin || y == box_ymax) && (x >= box_xmin) && (x <= box_xmax);
  assign overlay = overlay_en && found && iVGA_BLANK_N && (on_vert || on_horz);

  // Output stream: one register stage. Blanked RGB is forced to zero.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_HS      <= 1'b0;
      oVGA_VS      <= 1'b0;
      oVGA_SYNC_N  <= 1'b0;
      oVGA_BLANK_N <= 1'b0;
    end else begin
      oVGA_HS      <= iVGA_HS;
      oVGA_VS      <= iVGA_VS;
      oVGA_SYNC_N  <= iVGA_SYNC_N;
      oVGA_BLANK_N <= iVGA_BLANK_N;
      if (!iVGA_BLANK_N) begin
        oVGA_R <= '0;
        oVGA_G <= '0;
        oVGA_B <= '0;
      end else if (overlay) begin
        oVGA_R <= 8'hFF;
        oVGA_G <= 8'h00;
        oVGA_B <= 8'h00;
      end else begin
        oVGA_R <= iVGA_R;
        oVGA_G <= iVGA_G;
        oVGA_B <= iVGA_B;
      end
    end
  end

endmodule
